// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access controller.
// Runs one load or store per instruction over a req/ack bus, formats store
// byte lanes, extends load data and stalls the pipeline while busy.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   alu_res_i           byte address of the access
//   wdata_i             store data
//   mem_rw_i            1 = store (wins over mem2reg_i)
//   mem_rd_ctrl_i       load type (LB/LH/LW/LBU/LHU, others = LW)
//   mem_wr_ctrl_i       store type (SB/SH/SW, 11 = SW)
//   mem2reg_i           1 = load
//   dmem_*              registered data-memory bus; dmem_rdata/dmem_ack inputs
//   stall_o             pipeline stall (combinational)
//   load_data_o         extended load result (registered)
//   valid_o             completion strobe, high in DONE
//   misalign_o          misaligned access flag (combinational)
//   bus_err_o           one-cycle timeout pulse, coincident with DONE
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] wdata_i,
  input  logic        mem_rw_i,
  input  logic [2:0]  mem_rd_ctrl_i,
  input  logic [1:0]  mem_wr_ctrl_i,
  input  logic        mem2reg_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        valid_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [1:0]     off_q;
  logic [2:0]     ld_type_q;

  logic           access_c, is_byte_c, is_half_c, aligned_c;
  logic           start_c, timeout_c;
  logic [3:0]     wstrb_c;
  logic [31:0]    wdata_c, shifted_c, ld_ext_c;
  logic [7:0]     byte_c;
  logic [15:0]    half_c;

  // Access size decode; the store controls win when both strobes are set.
  always_comb begin
    is_byte_c = 1'b0;
    is_half_c = 1'b0;
    if (mem_rw_i) begin
      case (mem_wr_ctrl_i)
        2'b00:   is_byte_c = 1'b1;
        2'b01:   is_half_c = 1'b1;
        default: ;
      endcase
    end else begin
      case (mem_rd_ctrl_i)
        3'b000, 3'b100: is_byte_c = 1'b1;
        3'b001, 3'b101: is_half_c = 1'b1;
        default:        ;
      endcase
    end
  end

  assign access_c  = mem_rw_i | mem2reg_i;
  assign aligned_c = is_byte_c | (is_half_c ? ~alu_res_i[0] : (alu_res_i[1:0] == 2'b00));

  // Store lane formatting.
  always_comb begin
    wstrb_c = 4'b1111;
    wdata_c = wdata_i;
    if (is_byte_c) begin
      wstrb_c = 4'b0001 << alu_res_i[1:0];
      wdata_c = {4{wdata_i[7:0]}};
    end else if (is_half_c) begin
      wstrb_c = alu_res_i[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{wdata_i[15:0]}};
    end
  end

  // Load lane extraction and extension; stores complete with zero.
  assign shifted_c = dmem_rdata >> {off_q, 3'b000};
  assign byte_c    = shifted_c[7:0];
  assign half_c    = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    ld_ext_c = dmem_rdata;
    case (ld_type_q)
      3'b000:  ld_ext_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  ld_ext_c = {{16{half_c[15]}}, half_c};
      3'b100:  ld_ext_c = {24'd0, byte_c};
      3'b101:  ld_ext_c = {16'd0, half_c};
      default: ;
    endcase
    if (dmem_we) ld_ext_c = 32'd0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, stall and misalign decode.
  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    start_c    = 1'b0;
    timeout_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_c) begin
          if (aligned_c) begin
            stall_o = 1'b1;
            start_c = 1'b1;
            state_d = WAIT;
          end else begin
            misalign_o = 1'b1;
          end
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (dmem_ack) begin
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Pipeline must be free to flush while reset is held.
    if (rst) stall_o = 1'b0;
  end

  // Registered bus and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'd0;
      dmem_wdata  <= 32'd0;
      dmem_wstrb  <= 4'd0;
      load_data_o <= 32'd0;
      valid_o     <= 1'b0;
      bus_err_o   <= 1'b0;
      cnt_q       <= '0;
      off_q       <= 2'd0;
      ld_type_q   <= 3'd0;
    end else begin
      valid_o   <= 1'b0;
      bus_err_o <= 1'b0;
      if (start_c) begin
        dmem_req   <= 1'b1;
        dmem_we    <= mem_rw_i;
        dmem_addr  <= {alu_res_i[31:2], 2'b00};
        dmem_wdata <= mem_rw_i ? wdata_c : 32'd0;
        dmem_wstrb <= mem_rw_i ? wstrb_c : 4'd0;
        off_q      <= alu_res_i[1:0];
        ld_type_q  <= mem_rd_ctrl_i;
        cnt_q      <= '0;
      end
      if (state_q == WAIT) begin
        if (dmem_ack) begin
          load_data_o <= ld_ext_c;
          valid_o     <= 1'b1;
          dmem_req    <= 1'b0;
          dmem_we     <= 1'b0;
          dmem_wstrb  <= 4'd0;
        end else if (timeout_c) begin
          load_data_o <= 32'd0;
          valid_o     <= 1'b1;
          bus_err_o   <= 1'b1;
          dmem_req    <= 1'b0;
          dmem_we     <= 1'b0;
          dmem_wstrb  <= 4'd0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a small behavioural model.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_res_i = '0, wdata_i = '0, dmem_rdata = '0;
  logic        mem_rw_i = 1'b0, mem2reg_i = 1'b0, dmem_ack = 1'b0;
  logic [2:0]  mem_rd_ctrl_i = '0;
  logic [1:0]  mem_wr_ctrl_i = '0;
  logic        dmem_req, dmem_we, stall_o, valid_o, misalign_o, bus_err_o;
  logic [31:0] dmem_addr, dmem_wdata, load_data_o;
  logic [3:0]  dmem_wstrb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .alu_res_i(alu_res_i), .wdata_i(wdata_i),
    .mem_rw_i(mem_rw_i), .mem_rd_ctrl_i(mem_rd_ctrl_i), .mem_wr_ctrl_i(mem_wr_ctrl_i),
    .mem2reg_i(mem2reg_i), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall_o(stall_o), .load_data_o(load_data_o), .valid_o(valid_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  // ---------------- reference model ----------------
  function automatic int size_of(input logic rw, input logic [2:0] rdc, input logic [1:0] wrc);
    if (rw) return (wrc == 2'd0) ? 1 : (wrc == 2'd1) ? 2 : 4;
    if (rdc == 3'd0 || rdc == 3'd4) return 1;
    if (rdc == 3'd1 || rdc == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] addr, rdata, input logic [2:0] rdc);
    int     sz;
    longint v;
    sz = size_of(1'b0, rdc, 2'd0);
    v  = (longint'(rdata) >> (8 * (addr % 4))) & ((longint'(1) << (8 * sz)) - 1);
    if ((rdc == 3'd0 || rdc == 3'd1) && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return 32'(v);
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [31:0] addr, input logic [1:0] wrc);
    int sz;
    sz = size_of(1'b1, 3'd0, wrc);
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [1:0] wrc);
    int sz;
    sz = size_of(1'b1, 3'd0, wrc);
    if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  // ---------------- access driver (observes, does not judge) ----------------
  // ack_delay: number of WAIT cycles without ack before the ack cycle; -1 = never.
  task automatic run_access(
    input  logic [31:0] addr, wd, input logic rw, m2r,
    input  logic [2:0] rdc, input logic [1:0] wrc,
    input  int ack_delay, input logic [31:0] rdata,
    output int stalls, output logic [31:0] o_addr, o_wdata, output logic [3:0] o_wstrb,
    output logic o_we, output logic [31:0] o_ld, output logic o_berr,
    output logic done_seen, output logic o_dstall, output logic unstable);
    int waits;
    alu_res_i = addr; wdata_i = wd; mem_rw_i = rw; mem2reg_i = m2r;
    mem_rd_ctrl_i = rdc; mem_wr_ctrl_i = wrc;
    stalls = 0; waits = 0; done_seen = 0; o_dstall = 0; unstable = 0;
    o_addr = '0; o_wdata = '0; o_wstrb = '0; o_we = 0; o_ld = '0; o_berr = 0;
    for (int c = 0; c < 60; c++) begin
      if (valid_o) begin
        done_seen = 1; o_ld = load_data_o; o_berr = bus_err_o; o_dstall = stall_o;
        break;
      end
      if (dmem_req) begin
        if (waits > 0 && (o_addr !== dmem_addr || o_wdata !== dmem_wdata ||
                          o_wstrb !== dmem_wstrb || o_we !== dmem_we)) unstable = 1;
        o_addr = dmem_addr; o_wdata = dmem_wdata; o_wstrb = dmem_wstrb; o_we = dmem_we;
        dmem_ack   = (ack_delay >= 0) && (waits == ack_delay);
        dmem_rdata = rdata;
        waits++;
      end else begin
        dmem_ack = 1'b0;
      end
      #1;
      if (stall_o) stalls++;
      @(posedge clk); #1;
    end
    mem_rw_i = 1'b0; mem2reg_i = 1'b0; dmem_ack = 1'b0;
    if (done_seen) begin @(posedge clk); #1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; mem2reg_i = 1'b1; mem_rd_ctrl_i = 3'd2; alu_res_i = 32'h100;
    @(posedge clk); @(posedge clk); #1;
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall got %0b want 0", stall_o); end
    tests++; if ({dmem_req, dmem_we, dmem_wstrb, valid_o, bus_err_o} !== 8'd0) begin fails++;
      $display("FAIL reset_ctl got req%0b we%0b strb%h v%0b be%0b want zeros", dmem_req, dmem_we, dmem_wstrb, valid_o, bus_err_o); end
    tests++; if ({dmem_addr, dmem_wdata, load_data_o} !== 96'd0) begin fails++;
      $display("FAIL reset_data got addr%h wd%h ld%h want 0", dmem_addr, dmem_wdata, load_data_o); end
    mem2reg_i = 1'b0; rst = 1'b0;
    // Ack outside WAIT must be ignored.
    dmem_ack = 1'b1; @(posedge clk); #1; @(posedge clk); #1; dmem_ack = 1'b0;
    tests++; if (valid_o !== 1'b0 || dmem_req !== 1'b0) begin fails++;
      $display("FAIL idle_ack got valid%0b req%0b want 0 0", valid_o, dmem_req); end
  endtask

  task automatic test_lw();
    int st; logic [31:0] a, wd, ld; logic [3:0] sb; logic we, be, dn, ds, un;
    run_access(32'h100, 32'h0, 1'b0, 1'b1, 3'd2, 2'd0, 0, 32'hDEADBEEF, st, a, wd, sb, we, ld, be, dn, ds, un);
    tests++; if (st !== 2) begin fails++; $display("FAIL lw_stall got %0d want 2", st); end
    tests++; if (a !== 32'h100 || sb !== 4'h0 || we !== 1'b0) begin fails++;
      $display("FAIL lw_bus got addr%h strb%h we%0b want 100 0 0", a, sb, we); end
    tests++; if (dn !== 1'b1 || ld !== 32'hDEADBEEF || ds !== 1'b0 || be !== 1'b0) begin fails++;
      $display("FAIL lw_done got done%0b ld%h stall%0b err%0b want 1 deadbeef 0 0", dn, ld, ds, be); end
  endtask

  task automatic test_lb();
    int st; logic [31:0] a, wd, ld; logic [3:0] sb; logic we, be, dn, ds, un;
    run_access(32'h103, 32'h0, 1'b0, 1'b1, 3'd0, 2'd0, 1, 32'h80123456, st, a, wd, sb, we, ld, be, dn, ds, un);
    tests++; if (ld !== 32'hFFFFFF80 || st !== 3) begin fails++;
      $display("FAIL lb got %h stalls %0d want ffffff80 3", ld, st); end
    run_access(32'h103, 32'h0, 1'b0, 1'b1, 3'd4, 2'd0, 0, 32'h80123456, st, a, wd, sb, we, ld, be, dn, ds, un);
    tests++; if (ld !== 32'h00000080) begin fails++; $display("FAIL lbu got %h want 00000080", ld); end
  endtask

  task automatic test_sh();
    int st; logic [31:0] a, wd, ld; logic [3:0] sb; logic we, be, dn, ds, un;
    run_access(32'h202, 32'h0000ABCD, 1'b1, 1'b0, 3'd0, 2'd1, 2, 32'h12345678, st, a, wd, sb, we, ld, be, dn, ds, un);
    tests++; if (we !== 1'b1 || a !== 32'h200 || sb !== 4'b1100 || wd !== 32'hABCDABCD) begin fails++;
      $display("FAIL sh_bus got we%0b addr%h strb%h wd%h want 1 200 c abcdabcd", we, a, sb, wd); end
    tests++; if (st !== 4 || un !== 1'b0 || ld !== 32'd0) begin fails++;
      $display("FAIL sh_timing got stalls%0d unstable%0b ld%h want 4 0 0", st, un, ld); end
  endtask

  task automatic test_misalign();
    logic req_seen, bad;
    logic [31:0] a; logic rw; logic [2:0] rdc; logic [1:0] wrc; int sz;
    alu_res_i = 32'h106; mem2reg_i = 1'b1; mem_rw_i = 1'b0; mem_rd_ctrl_i = 3'd2;
    req_seen = 0; bad = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (misalign_o !== 1'b1 || stall_o !== 1'b0) bad = 1;
      if (dmem_req !== 1'b0) req_seen = 1;
      @(posedge clk); #1;
    end
    tests++; if (bad || req_seen) begin fails++;
      $display("FAIL misalign_lw got flag%0b stall%0b req%0b want 1 0 0", misalign_o, stall_o, req_seen); end
    mem2reg_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; rw = 1'($urandom); rdc = 3'($urandom); wrc = 2'($urandom);
      sz = size_of(rw, rdc, wrc);
      mem_rw_i = rw; mem2reg_i = ~rw; alu_res_i = a; mem_rd_ctrl_i = rdc; mem_wr_ctrl_i = wrc;
      #1;
      if (misalign_o !== ((a % sz) != 0) || stall_o !== ((a % sz) == 0)) begin
        bad = 1;
        $display("FAIL misalign_rand addr %h rw %0b got flag%0b stall%0b", a, rw, misalign_o, stall_o);
      end
      mem_rw_i = 1'b0; mem2reg_i = 1'b0; #1;
    end
    tests++; if (bad) fails++;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int st; logic [31:0] a, wd, ld; logic [3:0] sb; logic we, be, dn, ds, un;
    run_access(32'h400, 32'h0, 1'b0, 1'b1, 3'd2, 2'd0, -1, 32'h55555555, st, a, wd, sb, we, ld, be, dn, ds, un);
    tests++; if (dn !== 1'b1 || be !== 1'b1 || ld !== 32'd0) begin fails++;
      $display("FAIL timeout_done got done%0b err%0b ld%h want 1 1 0", dn, be, ld); end
    tests++; if (st !== TO + 1) begin fails++; $display("FAIL timeout_stall got %0d want %0d", st, TO + 1); end
    tests++; if (bus_err_o !== 1'b0 || dmem_req !== 1'b0) begin fails++;
      $display("FAIL timeout_pulse got err%0b req%0b after DONE want 0 0", bus_err_o, dmem_req); end
  endtask

  task automatic test_back_to_back();
    int st1, st2; logic [31:0] a, wd, ld; logic [3:0] sb; logic we, be, dn, ds, un;
    run_access(32'h500, 32'h11223344, 1'b1, 1'b0, 3'd0, 2'd2, 0, 32'h0, st1, a, wd, sb, we, ld, be, dn, ds, un);
    run_access(32'h504, 32'h99887766, 1'b1, 1'b0, 3'd0, 2'd3, 0, 32'h0, st2, a, wd, sb, we, ld, be, dn, ds, un);
    tests++; if (st1 !== 2 || st2 !== 2 || a !== 32'h504 || sb !== 4'hF || wd !== 32'h99887766) begin fails++;
      $display("FAIL b2b got st%0d/%0d addr%h strb%h wd%h want 2/2 504 f 99887766", st1, st2, a, sb, wd); end
  endtask

  task automatic test_random();
    int st, dly, sz, bad;
    logic [31:0] addr, wdr, rd, a, wd, ld; logic [3:0] sb; logic we, be, dn, ds, un;
    logic rw, m2r; logic [2:0] rdc; logic [1:0] wrc;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom); m2r = rw ? 1'($urandom) : 1'b1;
      rdc = 3'($urandom); wrc = 2'($urandom);
      sz = size_of(rw, rdc, wrc);
      addr = $urandom & ~(32'(sz) - 32'd1);
      wdr = $urandom; rd = $urandom; dly = $urandom_range(0, 2);
      run_access(addr, wdr, rw, m2r, rdc, wrc, dly, rd, st, a, wd, sb, we, ld, be, dn, ds, un);
      if (dn !== 1'b1 || st !== 2 + dly || un !== 1'b0 || be !== 1'b0 || we !== rw ||
          a !== (addr & 32'hFFFF_FFFC) ||
          sb !== (rw ? exp_wstrb(addr, wrc) : 4'd0) ||
          (rw && wd !== exp_wdata(wdr, wrc)) ||
          ld !== (rw ? 32'd0 : exp_load(addr, rd, rdc))) begin
        bad++;
        $display("FAIL random[%0d] rw%0b addr%h got st%0d a%h sb%h wd%h ld%h", i, rw, addr, st, a, sb, wd, ld);
      end
    end
    tests++; if (bad != 0) fails++;
  endtask

  task automatic test_rst_in_wait();
    logic bad;
    alu_res_i = 32'h300; mem2reg_i = 1'b1; mem_rw_i = 1'b0; mem_rd_ctrl_i = 3'd2; dmem_ack = 1'b0;
    @(posedge clk); #1;   // WAIT 1
    @(posedge clk); #1;   // WAIT 2
    tests++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL rstwait_req got %0b want 1", dmem_req); end
    rst = 1'b1; #1;
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL rstwait_stall got %0b want 0", stall_o); end
    @(posedge clk); #1;
    tests++; if ({dmem_req, dmem_we, dmem_wstrb, valid_o, bus_err_o} !== 8'd0 ||
                 {dmem_addr, dmem_wdata, load_data_o} !== 96'd0) begin fails++;
      $display("FAIL rstwait_vals got req%0b addr%h ld%h want 0", dmem_req, dmem_addr, load_data_o); end
    rst = 1'b0; mem2reg_i = 1'b0; mem_rw_i = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      #1; if (stall_o !== 1'b0 || dmem_req !== 1'b0) bad = 1;
      @(posedge clk); #1;
    end
    tests++; if (bad) begin fails++; $display("FAIL alu_only got stall%0b req%0b want 0 0", stall_o, dmem_req); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb();
    test_sh();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_random();
    test_rst_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
